// File: rtl/imm_seq_ctrl.sv
// Immediate sequencer: SEXT/ZEXT of 22-bit fields and HI10+LO22 composition.
// IMMGEN_ZEXT_EN enables mode 01 (ZEXT22); otherwise mode 01 raises err.
module imm_seq_ctrl #(
  parameter int OUT_W = 32,
  parameter int IN_W  = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic             err,
  output logic             hi_pend
);

  localparam int HI_W = OUT_W - IN_W;

  typedef enum logic {
    IDLE,
    HI_WAIT
  } state_t;

  state_t state;
  logic [HI_W-1:0] hi_reg;

  logic in_xfer;
  logic out_xfer;
  logic m_sx;
  logic m_zx;
  logic m_hi;
  logic m_lo;
  logic produce;
  logic bad;
  logic ld_hi;
  logic lo_ok;
  logic [OUT_W-1:0] res;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign hi_pend  = (state == HI_WAIT);

  assign m_sx = (mode == 2'b00);
  assign m_zx = (mode == 2'b01);
  assign m_hi = (mode == 2'b10);
  assign m_lo = (mode == 2'b11);

  always_comb begin
    produce = 1'b0;
    bad     = 1'b0;
    ld_hi   = 1'b0;
    lo_ok   = 1'b0;
    res     = '0;
    unique case (1'b1)
      m_sx: begin
        produce = 1'b1;
        res     = {{HI_W{imm_in[IN_W-1]}}, imm_in};
      end
      m_zx: begin
`ifdef IMMGEN_ZEXT_EN
        produce = 1'b1;
        res     = {{HI_W{1'b0}}, imm_in};
`else
        bad     = 1'b1;
`endif
      end
      m_hi: ld_hi = 1'b1;
      m_lo: begin
        // a LO22 without a pending HI is consumed but flagged
        if (state == HI_WAIT) begin
          produce = 1'b1;
          lo_ok   = 1'b1;
          res     = {hi_reg, imm_in};
        end else begin
          bad     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_reg    <= '0;
      out_valid <= 1'b0;
      imm_out   <= '0;
      err       <= 1'b0;
    end else begin
      err <= in_xfer && bad;
      if (in_xfer && produce) begin
        out_valid <= 1'b1;
        imm_out   <= res;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (in_xfer && ld_hi) begin
        hi_reg <= imm_in[HI_W-1:0];
        state  <= HI_WAIT;
      end else if (in_xfer && lo_ok) begin
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Directed vector bench for imm_seq_ctrl.
// Table rows are one cycle each; reset corner handled by hand.
module tb_imm_seq_ctrl;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [1:0] SX = 2'b00;
  localparam logic [1:0] ZX = 2'b01;
  localparam logic [1:0] HI = 2'b10;
  localparam logic [1:0] LO = 2'b11;

`ifdef IMMGEN_ZEXT_EN
  localparam logic        Z_OV  = 1'b1;
  localparam logic        Z_ERR = 1'b0;
`else
  localparam logic        Z_OV  = 1'b0;
  localparam logic        Z_ERR = 1'b1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] imm_in;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_out;
  logic        err;
  logic        hi_pend;

  int ncmp = 0;
  int nbad = 0;

  imm_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .err       (err),
    .hi_pend   (hi_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  m;
    logic [21:0] imm;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic [31:0] q;
    logic        er;
    logic        hp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic v, input logic [1:0] m, input logic [21:0] imm,
    input logic ordy, input logic rdy, input logic ov,
    input logic [31:0] q, input logic er, input logic hp);
    vec_t r;
    r.v = v; r.m = m; r.imm = imm; r.ordy = ordy; r.rdy = rdy;
    r.ov = ov; r.q = q; r.er = er; r.hp = hp;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t r, input int idx);
    string s;
    @(negedge clk);
    in_valid  = r.v;
    mode      = r.m;
    imm_in    = r.imm;
    out_ready = r.ordy;
    #1;
    s = $sformatf("row%0d", idx);
    chk({s, ".in_ready"}, {31'b0, in_ready}, {31'b0, r.rdy});
    @(posedge clk);
    #1;
    chk({s, ".out_valid"}, {31'b0, out_valid}, {31'b0, r.ov});
    if (r.ov) chk({s, ".imm_out"}, imm_out, r.q);
    chk({s, ".err"}, {31'b0, err}, {31'b0, r.er});
    chk({s, ".hi_pend"}, {31'b0, hi_pend}, {31'b0, r.hp});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, ".imm_out"}, imm_out, 32'd0);
    chk({nm, ".err"}, {31'b0, err}, 32'd0);
    chk({nm, ".hi_pend"}, {31'b0, hi_pend}, 32'd0);
    chk({nm, ".in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t r;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mode = SX;
    imm_in = '0;
    out_ready = 1'b1;

    //   v  mode imm          ordy rdy ov  q             err hp
    add(T, SX, 22'h200000, T, T, T, 32'hFFE00000, F, F);
    add(T, SX, 22'h1FFFFF, T, T, T, 32'h001FFFFF, F, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, HI, 22'h0002AB, T, T, F, 32'h0,        F, T);
    add(T, LO, 22'h155555, T, T, T, 32'hAAD55555, F, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, LO, 22'h000000, T, T, F, 32'h0,        T, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, HI, 22'h0003FF, T, T, F, 32'h0,        F, T);
    add(T, HI, 22'h000001, T, T, F, 32'h0,        F, T);
    add(T, LO, 22'h000000, T, T, T, 32'h00400000, F, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, SX, 22'h000005, F, T, T, 32'h00000005, F, F);
    add(T, SX, 22'h3FFFFF, F, F, T, 32'h00000005, F, F);
    add(T, SX, 22'h3FFFFF, F, F, T, 32'h00000005, F, F);
    add(T, SX, 22'h3FFFFF, F, F, T, 32'h00000005, F, F);
    add(T, SX, 22'h3FFFFF, T, T, T, 32'hFFFFFFFF, F, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, ZX, 22'h3FFFFF, T, T, Z_OV, 32'h003FFFFF, Z_ERR, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);
    add(T, SX, 22'h000007, T, T, T, 32'h00000007, F, F);
    add(T, HI, 22'h000155, T, T, F, 32'h0,        F, T);
    add(T, LO, 22'h000000, T, T, T, 32'h55400000, F, F);
    add(F, SX, 22'h000000, T, T, F, 32'h0,        F, F);

    #2;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // buffer held, then HI10 accepted while it drains, then async reset
    add(T, SX, 22'h000009, F, T, T, 32'h00000009, F, F);
    step(tbl[tbl.size()-1], 100);
    add(T, HI, 22'h000033, T, T, F, 32'h0, F, T);
    step(tbl[tbl.size()-1], 101);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    chk_reset("midreset_hold");
    rst_n = 1'b1;
    add(T, LO, 22'h000001, T, T, F, 32'h0, T, F);
    step(tbl[tbl.size()-1], 102);
    add(F, SX, 22'h000000, T, T, F, 32'h0, F, F);
    step(tbl[tbl.size()-1], 103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
